// File: rtl/vga_480p_capture_if.sv
// Video timing link from the 480p source into the capture block: syncs, active qualifier and pixel data.
interface vga_480p_capture_if;
    logic       hsync;
    logic       vsync;
    logic       href;
    logic [8:0] data;

    modport master (output hsync, vsync, href, data);
    modport slave  (input  hsync, vsync, href, data);
endinterface

// File: rtl/vga_480p_capture.sv
// 480p capture: samples the timing link, checks the active window and writes pixels in raster order.
// Optional feature: define CAPTURE_CHECKSUM_EN to add a per-frame 16-bit checksum of written pixel data.
module vga_480p_capture #(
    parameter int ACT_PIXELS   = 640,
    parameter int ACT_LINES    = 480,
    parameter int HREF_TO_DATA = 1,
    parameter int TIMEOUT      = 2048
) (
    input  logic              clk27,
    input  logic              reset,
    vga_480p_capture_if.slave vid,
    output logic              wr_en,
    output logic [18:0]       wr_addr,
    output logic [8:0]        wr_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              locked,
    output logic              err_pixels,
    output logic              err_lines,
    output logic              err_overflow,
    output logic [11:0]       pix_meas,
`ifdef CAPTURE_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic [11:0]       line_meas
);
    localparam logic [18:0] LAST_INDEX = 19'(ACT_PIXELS * ACT_LINES);
    localparam logic [11:0] PIX_EXP    = 12'(ACT_PIXELS);
    localparam logic [11:0] LINE_EXP   = 12'(ACT_LINES);
    localparam logic [11:0] WD_LAST    = 12'(TIMEOUT - 1);

    typedef enum logic {SEARCH, CAPTURE} state_t;
    state_t state_q, state_d;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    logic       hs1_q, vs1_q, href1_q, href2_q;
    logic       hs_prev_q, vs_prev_q, href_a_prev_q;
    logic [8:0] data1_q;
    logic       href_a, hs_fall, vs_fall, href_fall;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk27 or negedge reset) begin
        if (!reset) begin
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            href1_q       <= 1'b0;
            href2_q       <= 1'b0;
            data1_q       <= '0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            href_a_prev_q <= 1'b0;
        end else begin
            hs1_q         <= vid.hsync;
            vs1_q         <= vid.vsync;
            href1_q       <= vid.href;
            data1_q       <= vid.data;
            href2_q       <= href1_q;
            hs_prev_q     <= hs1_q;
            vs_prev_q     <= vs1_q;
            href_a_prev_q <= href_a;
        end
    end

    // The href falling edge is taken on the data-aligned href so the last pixel is counted first.
    assign href_a    = (HREF_TO_DATA != 0) ? href2_q : href1_q;
    assign hs_fall   = hs_prev_q & ~hs1_q;
    assign vs_fall   = vs_prev_q & ~vs1_q;
    assign href_fall = href_a_prev_q & ~href_a;

    logic [18:0] pix_index_q, wr_addr_q;
    logic [8:0]  wr_data_q;
    logic [11:0] line_len_q, line_cnt_q, wd_q, pix_meas_q, line_meas_q;
    logic [1:0]  good_cnt_q;
    logic        wr_en_q, frame_start_q, frame_done_q, frame_ok_q;
    logic        err_pixels_q, err_lines_q, err_overflow_q;

    always_ff @(posedge clk27 or negedge reset) begin
        if (!reset) state_q <= SEARCH;
        else        state_q <= state_d;
    end

    logic do_write, do_ovf, do_count, do_line, do_close, do_start, do_timeout;

    // NOTE: every always_comb output is defaulted first so no path can infer a latch.
    always_comb begin
        do_write   = 1'b0;
        do_ovf     = 1'b0;
        do_count   = 1'b0;
        do_line    = 1'b0;
        do_close   = 1'b0;
        do_start   = 1'b0;
        do_timeout = 1'b0;
        unique case (state_q)
            SEARCH:  do_start = vs_fall;
            CAPTURE: begin
                do_timeout = (wd_q == WD_LAST) && !hs_fall && !vs_fall;
                do_close   = vs_fall;
                do_start   = vs_fall;
                if (!do_timeout) begin
                    do_line  = href_fall;
                    do_count = href_a && !vs_fall;
                    do_write = do_count && (pix_index_q != LAST_INDEX);
                    do_ovf   = do_count && (pix_index_q == LAST_INDEX);
                end
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH:  if (vs_fall)    state_d = CAPTURE;
            CAPTURE: if (do_timeout) state_d = SEARCH;
        endcase
    end

    // A line ending in the closing cycle still belongs to the frame being closed.
    logic [11:0] line_cnt_close;
    logic        err_pix_close, lines_bad, close_ok;
    assign line_cnt_close = do_line ? sat_inc(line_cnt_q) : line_cnt_q;
    assign err_pix_close  = err_pixels_q | (do_line && (line_len_q != PIX_EXP));
    assign lines_bad      = (line_cnt_close != LINE_EXP);
    assign close_ok       = !(err_pix_close | err_overflow_q | lines_bad);

    always_ff @(posedge clk27 or negedge reset) begin
        if (!reset) begin
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            pix_index_q    <= '0;
            line_len_q     <= '0;
            line_cnt_q     <= '0;
            wd_q           <= '0;
            pix_meas_q     <= '0;
            line_meas_q    <= '0;
            good_cnt_q     <= '0;
            frame_start_q  <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_ok_q     <= 1'b0;
            err_pixels_q   <= 1'b0;
            err_lines_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            wr_en_q       <= do_write;
            frame_start_q <= do_start;
            frame_done_q  <= do_close;
            if (do_write) begin
                wr_addr_q   <= pix_index_q;
                wr_data_q   <= data1_q;
                pix_index_q <= pix_index_q + 19'd1;
            end
            if (do_ovf)   err_overflow_q <= 1'b1;
            if (do_count) line_len_q <= sat_inc(line_len_q);
            if (do_line) begin
                pix_meas_q <= line_len_q;
                line_cnt_q <= sat_inc(line_cnt_q);
                line_len_q <= '0;
                if (line_len_q != PIX_EXP) err_pixels_q <= 1'b1;
            end
            if (do_close) begin
                line_meas_q <= line_cnt_close;
                frame_ok_q  <= close_ok;
                err_lines_q <= lines_bad;
                if (!close_ok)                good_cnt_q <= 2'd0;
                else if (good_cnt_q != 2'd2)  good_cnt_q <= good_cnt_q + 2'd1;
            end
            if (do_timeout) good_cnt_q <= 2'd0;
            if (do_start) begin
                pix_index_q    <= '0;
                line_cnt_q     <= '0;
                line_len_q     <= '0;
                err_pixels_q   <= 1'b0;
                err_overflow_q <= 1'b0;
            end
            if (state_q == CAPTURE && !hs_fall && !do_timeout) wd_q <= sat_inc(wd_q);
            else                                               wd_q <= '0;
        end
    end

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] sum_q, checksum_q;
    always_ff @(posedge clk27 or negedge reset) begin
        if (!reset) begin
            sum_q      <= '0;
            checksum_q <= '0;
        end else begin
            if (do_close)      checksum_q <= sum_q;
            if (do_start)      sum_q <= '0;
            else if (do_write) sum_q <= sum_q + {7'd0, data1_q};
        end
    end
    assign checksum = checksum_q;
`endif

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign frame_start  = frame_start_q;
    assign frame_done   = frame_done_q;
    assign frame_ok     = frame_ok_q;
    assign locked       = (good_cnt_q == 2'd2);
    assign err_pixels   = err_pixels_q;
    assign err_lines    = err_lines_q;
    assign err_overflow = err_overflow_q;
    assign pix_meas     = pix_meas_q;
    assign line_meas    = line_meas_q;
endmodule

// File: tb/tb_vga_480p_capture.sv
// Bench for vga_480p_capture on a scaled-down raster (8x4 active in 24x12 total) with a short watchdog.
module tb_vga_480p_capture;
    localparam int AP = 8, AL = 4, TO = 64;
    localparam int H_TOT = 24, HS_W = 3, H_ACT = 8;
    localparam int V_TOT = 12, VS_W = 2, V_ACT = 4;

    logic clk27 = 1'b0;
    logic reset = 1'b0;
    logic        wr_en, frame_start, frame_done, frame_ok, locked;
    logic        err_pixels, err_lines, err_overflow;
    logic [18:0] wr_addr;
    logic [8:0]  wr_data;
    logic [11:0] pix_meas, line_meas;
`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] checksum;
    logic [15:0] fd_ck;
`endif

    vga_480p_capture_if vid();

    vga_480p_capture #(.ACT_PIXELS(AP), .ACT_LINES(AL), .HREF_TO_DATA(1), .TIMEOUT(TO)) dut (
        .clk27(clk27), .reset(reset), .vid(vid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start), .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .err_pixels(err_pixels), .err_lines(err_lines), .err_overflow(err_overflow),
        .pix_meas(pix_meas),
`ifdef CAPTURE_CHECKSUM_EN
        .checksum(checksum),
`endif
        .line_meas(line_meas)
    );

    always #5 clk27 = ~clk27;

    int total = 0, bad = 0;
    int cyc = 0, fs_cnt = 0, fd_cnt = 0, n_wr = 0, bad_addr = 0, bad_data = 0, tot_wr = 0;
    int fd_nwr = 0, pix = 0, hs_fall_cyc = 0, wr_mark = 0;
    logic fd_ok = 1'b0, fd_locked = 1'b0, fd_el = 1'b0;
    logic [11:0] fd_lm = '0;
    logic [8:0] data_pend = '0;
    bit ff_mode = 1'b0, hs_stuck = 1'b0;

    typedef struct {
        int n_lines; int short_line;
        int e_nwr; int e_pm; bit e_ep; bit e_eo;
        bit c_ok; int c_lm; bit c_el; bit c_lock;
    } row_t;
    row_t rows[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Samples outputs on the falling edge and tracks the write stream of the current frame.
    task automatic tick();
        @(negedge clk27);
        cyc++;
        if (frame_done) begin
            fd_cnt++;
            fd_nwr = n_wr; fd_ok = frame_ok; fd_locked = locked; fd_el = err_lines; fd_lm = line_meas;
`ifdef CAPTURE_CHECKSUM_EN
            fd_ck = checksum;
`endif
        end
        if (frame_start) begin
            fs_cnt++; n_wr = 0; bad_addr = 0; bad_data = 0;
        end
        if (wr_en) begin
            if (wr_addr != 19'(n_wr)) bad_addr++;
            if (wr_data != (ff_mode ? 9'h1FF : wr_addr[8:0])) bad_data++;
            n_wr++; tot_wr++;
        end
    endtask

    task automatic drive_pins(input logic hs, input logic vs, input logic hr);
        vid.hsync = hs; vid.vsync = vs; vid.href = hr; vid.data = data_pend;
        if (hr) begin
            data_pend = ff_mode ? 9'h1FF : 9'(pix % 512);
            pix++;
        end
        tick();
    endtask

    task automatic drive_line(input int line, input int href_len);
        for (int h = 0; h < H_TOT; h++) begin
            if (!hs_stuck && h == 0) hs_fall_cyc = cyc;
            drive_pins(hs_stuck ? 1'b1 : (h >= HS_W), line >= VS_W,
                       (h >= H_ACT) && (h < H_ACT + href_len));
        end
    endtask

    task automatic drive_frame(input int n_lines, input int short_line);
        pix = 0;
        for (int line = 0; line < V_TOT; line++) begin
            int idx, len;
            idx = line - V_ACT;
            len = (idx >= 0 && idx < n_lines) ? ((idx == short_line) ? AP - 1 : AP) : 0;
            drive_line(line, len);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {wr_en, wr_addr, wr_data, frame_start, frame_done, frame_ok, locked,
                     err_pixels, err_lines, err_overflow, pix_meas, line_meas}, 64'd0);
    endtask

    initial begin
        int fs0, fd0, wr0;
        rows[0] = '{AL,     -1, 32, 8, 0, 0, 1, 4, 0, 0};
        rows[1] = '{AL,     -1, 32, 8, 0, 0, 1, 4, 0, 1};
        rows[2] = '{AL,      3, 31, 7, 1, 0, 0, 4, 0, 0};
        rows[3] = '{AL,     -1, 32, 8, 0, 0, 1, 4, 0, 0};
        rows[4] = '{AL + 1, -1, 32, 8, 0, 1, 0, 5, 1, 0};
        rows[5] = '{AL,     -1, 32, 8, 0, 0, 1, 4, 0, 0};
        rows[6] = '{AL,     -1, 32, 8, 0, 0, 1, 4, 0, 1};
        rows[7] = '{AL,     -1, 32, 8, 0, 0, 1, 4, 0, 1};

        vid.hsync = 1'b1; vid.vsync = 1'b1; vid.href = 1'b0; vid.data = '0;
        repeat (3) tick();
        check_all_zero("reset_outputs");
        reset = 1'b1;

        // href with no vsync edge yet must be ignored.
        drive_line(6, AP);
        drive_line(7, AP);
        check("search_no_writes", tot_wr, 0);
        check("search_no_frame_start", fs_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            fs0 = fs_cnt; fd0 = fd_cnt;
            drive_frame(rows[i].n_lines, rows[i].short_line);
            check($sformatf("r%0d_frame_start", i), fs_cnt - fs0, 1);
            check($sformatf("r%0d_writes", i), n_wr, rows[i].e_nwr);
            check($sformatf("r%0d_addr_data", i), bad_addr + bad_data, 0);
            check($sformatf("r%0d_pix_meas", i), pix_meas, rows[i].e_pm);
            check($sformatf("r%0d_err_pixels", i), err_pixels, rows[i].e_ep);
            check($sformatf("r%0d_err_overflow", i), err_overflow, rows[i].e_eo);
            if (i == 0) check("r0_no_close", fd_cnt - fd0, 0);
            else begin
                check($sformatf("r%0d_close_cnt", i - 1), fd_cnt - fd0, 1);
                check($sformatf("r%0d_close_writes", i - 1), fd_nwr, rows[i - 1].e_nwr);
                check($sformatf("r%0d_frame_ok", i - 1), fd_ok, rows[i - 1].c_ok);
                check($sformatf("r%0d_line_meas", i - 1), fd_lm, rows[i - 1].c_lm);
                check($sformatf("r%0d_err_lines", i - 1), fd_el, rows[i - 1].c_el);
                check($sformatf("r%0d_locked", i - 1), fd_locked, rows[i - 1].c_lock);
            end
        end

        // Watchdog: hsync stops toggling after line 2 of a new frame.
        fs0 = fs_cnt; fd0 = fd_cnt;
        drive_line(0, 0); drive_line(1, 0); drive_line(2, 0);
        check("r7_close_locked", fd_locked, 1);
        check("r7_close_cnt", fd_cnt - fd0, 1);
        hs_stuck = 1'b1;
        wr_mark = tot_wr;
        for (int k = 0; k < 3 * TO; k++) begin
            int h;
            h = k % H_TOT;
            drive_pins(1'b1, 1'b1, (h >= H_ACT) && (h < H_ACT + AP));
            if (cyc == hs_fall_cyc + TO + 1) check("lock_before_timeout", locked, 1);
            if (cyc == hs_fall_cyc + TO + 2) begin
                check("lock_dropped_timeout", locked, 0);
                wr_mark = tot_wr;
            end
        end
        check("no_writes_after_timeout", tot_wr - wr_mark, 0);
        check("timeout_no_frame_events", (fs_cnt - fs0) + (fd_cnt - fd0 - 1), 1);
        hs_stuck = 1'b0;

        fs0 = fs_cnt; fd0 = fd_cnt;
        drive_frame(AL, -1);
        check("recapture_start", fs_cnt - fs0, 1);
        check("recapture_no_close", fd_cnt - fd0, 0);
        check("recapture_writes", n_wr, 32);
        check("recapture_addr_data", bad_addr + bad_data, 0);

        // Reset in the middle of a frame, after one active line was written.
        for (int line = 0; line < 5; line++) drive_line(line, (line >= V_ACT) ? AP : 0);
        check("pre_reset_close_ok", fd_ok, 1);
        check("pre_reset_line_writes", n_wr, 8);
        fd0 = fd_cnt; wr0 = tot_wr;
        reset = 1'b0;
        #1;
        check_all_zero("midframe_reset_outputs");
        repeat (3) drive_pins(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        for (int line = 5; line < V_TOT; line++) drive_line(line, (line < V_ACT + AL) ? AP : 0);
        check("reset_no_frame_done", fd_cnt - fd0, 0);
        check("reset_no_writes", tot_wr - wr0, 0);
        fs0 = fs_cnt;
        drive_frame(AL, -1);
        check("post_reset_start", fs_cnt - fs0, 1);
        check("post_reset_no_close", fd_cnt - fd0, 0);
        check("post_reset_writes", n_wr, 32);
        drive_frame(AL, -1);
        check("post_reset_close", fd_cnt - fd0, 1);
        check("post_reset_frame_ok", fd_ok, 1);
        check("post_reset_locked", fd_locked, 0);

`ifdef CAPTURE_CHECKSUM_EN
        ff_mode = 1'b1;
        drive_frame(AL, -1);
        check("ff_addr_data", bad_addr + bad_data, 0);
        ff_mode = 1'b0;
        drive_frame(AL, -1);
        check("checksum_ff", fd_ck, 16'h3FE0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
